decode_imm_ctrl: RTL

//  Fetch->decode skid buffer and immediate-format controller for the RV32I core.

---
 rtl/decode_imm_ctrl_if.sv | 44 ++++
 rtl/decode_imm_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_ctrl_if.sv
// rtl/decode_imm_ctrl_if.sv - fetch/decode handshake bundle for decode_imm_ctrl
//
// Purpose: groups the fetch-side push channel, the decode-side head channel,
//          the immediate-format controls and the stall counter.
// Signals:
//   in_valid/in_ready/in_instr/in_pc      fetch -> buffer push channel
//   flush                                 synchronous discard request
//   out_valid/out_ready/out_instr/out_pc  buffer head -> decode
//   ImmSrc/imm_used/illegal               immediate controls for sign_extend
//   stall_cnt                             saturating decode back-pressure count
// Modports: master = fetch/decode side (bench), slave = decode_imm_ctrl.

interface decode_imm_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [2:0]            ImmSrc;
  logic                  imm_used;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  ImmSrc, imm_used, illegal, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output ImmSrc, imm_used, illegal, stall_cnt
  );

endinterface

// File: rtl/decode_imm_ctrl.sv
// rtl/decode_imm_ctrl.sv - two-entry fetch->decode skid buffer with immediate-format decode
//
// Purpose: buffers up to two fetched instructions, presents the oldest one to
//          decode and derives the sign_extend immediate format from it.
//          A flush empties the buffer; decode back-pressure cycles are counted.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    decode_imm_ctrl_if.slave (push channel, head channel, ImmSrc,
//          imm_used, illegal, stall_cnt)
// Immediate format codes (ImmSrc):
//   I = 3'd0, S = 3'd1, B = 3'd2, U = 3'd3, I5 = 3'd4

module decode_imm_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_imm_ctrl_if.slave   bus
);

  // Buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // sign_extend immediate format codes
  localparam logic [2:0] SIGN_EXTEND_I  = 3'd0;
  localparam logic [2:0] SIGN_EXTEND_S  = 3'd1;
  localparam logic [2:0] SIGN_EXTEND_B  = 3'd2;
  localparam logic [2:0] SIGN_EXTEND_U  = 3'd3;
  localparam logic [2:0] SIGN_EXTEND_I5 = 3'd4;

  // RV32I major opcodes
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Shift-immediate funct3 values (slli / srli,srai)
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [DATA_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] tail_instr;
  logic [DATA_WIDTH-1:0] tail_pc;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic                  push;
  logic                  pop;

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [2:0]            imm_src;
  logic                  used;
  logic                  bad_op;

  // Handshake outputs depend on state only, so fetch and decode never see a
  // combinational loop through this buffer.
  assign bus.in_ready  = (state != ST_TWO);
  assign bus.out_valid = (state != ST_EMPTY);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_TWO;
          else if (pop && !push) state_nxt = ST_EMPTY;
        end
        ST_TWO: begin
          if (pop) state_nxt = ST_ONE;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Entry storage. The head register always holds the oldest instruction so
  // decode reads a fixed location; the tail only holds the second entry.
  // During a flush nothing is written, which drops any instruction pushed in
  // that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (!bus.flush) begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head_instr <= bus.in_instr;
            head_pc    <= bus.in_pc;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            // Head leaves as the new one arrives: new instr goes straight to head.
            head_instr <= bus.in_instr;
            head_pc    <= bus.in_pc;
          end else if (push) begin
            tail_instr <= bus.in_instr;
            tail_pc    <= bus.in_pc;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating back-pressure counter; a flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = head_pc;

  assign opcode = head_instr[6:0];
  assign f3     = head_instr[14:12];

  // Immediate-format decode of the head entry. With no valid head the
  // outputs rest at I/unused/legal so sign_extend never sees an invalid code.
  // JAL is reported illegal: this decoder has no J format.
  always_comb begin
    imm_src = SIGN_EXTEND_I;
    used    = 1'b0;
    bad_op  = 1'b0;
    if (bus.out_valid) begin
      case (opcode)
        OP_IMM: begin
          used = 1'b1;
          if ((f3 == F3_SLL) || (f3 == F3_SRX)) imm_src = SIGN_EXTEND_I5;
          else                                  imm_src = SIGN_EXTEND_I;
        end
        OP_LOAD, OP_JALR: begin
          imm_src = SIGN_EXTEND_I;
          used    = 1'b1;
        end
        OP_STORE: begin
          imm_src = SIGN_EXTEND_S;
          used    = 1'b1;
        end
        OP_BRANCH: begin
          imm_src = SIGN_EXTEND_B;
          used    = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          imm_src = SIGN_EXTEND_U;
          used    = 1'b1;
        end
        OP_REG: begin
          imm_src = SIGN_EXTEND_I;
          used    = 1'b0;
        end
        default: begin
          imm_src = SIGN_EXTEND_I;
          used    = 1'b0;
          bad_op  = 1'b1;
        end
      endcase
    end
  end

  assign bus.ImmSrc   = imm_src;
  assign bus.imm_used = used;
  assign bus.illegal  = bad_op;

endmodule
